// File: rtl/sb_rx_deser.sv
// -----------------------------------------------------------------------------
// sb_rx_deser
//
// Sideband serial receiver. Bits on dataPin_i are sampled on the falling edge
// of the forwarded clock clkPin_i, LSB first. Each word is followed by an idle
// gap of IDLE_UI forwarded-clock UIs. Completed words cross into the system
// clock domain through a gray-pointer asynchronous FIFO. The link layer reads
// them through a valid/ready interface.
//
// Optional feature macro: SB_RX_IDLE_CHECK_EN
//   defined   : a 1 seen during the idle gap raises framing_err_o. The receiver
//               then waits for IDLE_UI consecutive zero UIs before it accepts
//               the next word.
//   undefined : the idle gap ignores dataPin_i and framing_err_o is tied to 0.
//
// Parameters
//   DATA_W      word width in bits (>=8)
//   FIFO_DEPTH  FIFO depth in words (power of 2, >=2)
//   IDLE_UI     idle UIs after each word
//   SYNC_STG    synchroniser flops per crossing (>=2)
//
// Ports
//   clk            system clock
//   reset          asynchronous active-high reset, both clock domains
//   clkPin_i       forwarded serial clock, data sampled on its negedge
//   dataPin_i      serial data
//   data_o         FIFO head word, meaningful only while valid_o=1
//   valid_o        FIFO non-empty (clk domain view)
//   ready_i        consumer accepts the head word; pop on valid_o & ready_i
//   overflow_o     1-clk pulse: a completed word was dropped because FIFO full
//   framing_err_o  1-clk pulse: idle-gap violation (macro builds only)
//   level_o        words held in the FIFO as seen from the clk domain
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sb_rx_deser #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_UI    = 32,
    parameter int SYNC_STG   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clkPin_i,
    input  logic                          dataPin_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          overflow_o,
    output logic                          framing_err_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int BCW = $clog2(DATA_W);
    localparam int ICW = $clog2(IDLE_UI + 1);

    // The FIFO is full when the write gray pointer equals the read gray pointer
    // with its two top bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // =========================================================================
    // Serial domain (negedge clkPin_i)
    // =========================================================================
    typedef enum logic [1:0] {
        S_RECV   = 2'd0,
        S_IDLE   = 2'd1
`ifdef SB_RX_IDLE_CHECK_EN
        ,
        S_RESYNC = 2'd2
`endif
    } ser_state_t;

    ser_state_t                   state_q;
    logic [BCW-1:0]               bit_cnt_q;
    logic [ICW-1:0]               idle_cnt_q;
    // Holds the DATA_W-1 bits received so far. The final bit goes straight
    // from the pin into the FIFO, so the register is one bit short of a word.
    logic [DATA_W-2:0]            shift_q;
    logic [PW-1:0]                wbin_q;
    logic [PW-1:0]                wgray_q;
    logic                         ovf_tgl_q;
    logic [SYNC_STG-1:0][PW-1:0]  rsync_q;
`ifdef SB_RX_IDLE_CHECK_EN
    logic                         ferr_tgl_q;
`endif

    logic                         word_done;
    logic                         full;
    logic                         wr_en;
    logic [DATA_W-1:0]            wr_word;
    logic [PW-1:0]                wbin_d;

    assign word_done = (state_q == S_RECV) && (bit_cnt_q == BCW'(DATA_W - 1));
    // The read pointer seen here is SYNC_STG edges old. It can only lag the
    // true pointer, so the FIFO may look full early but never overwrites.
    assign full      = ((wgray_q ^ rsync_q[SYNC_STG-1]) == FULL_MASK);
    assign wr_en     = word_done && !full;
    assign wr_word   = {dataPin_i, shift_q};
    assign wbin_d    = wbin_q + 1'b1;

    always_ff @(negedge clkPin_i or posedge reset) begin
        if (reset) begin
            state_q    <= S_RECV;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            shift_q    <= '0;
            wbin_q     <= '0;
            wgray_q    <= '0;
            ovf_tgl_q  <= 1'b0;
`ifdef SB_RX_IDLE_CHECK_EN
            ferr_tgl_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RECV: begin
                    shift_q <= {dataPin_i, shift_q[DATA_W-2:1]};
                    if (word_done) begin
                        bit_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                        state_q    <= S_IDLE;
                        if (full) begin
                            ovf_tgl_q <= ~ovf_tgl_q;
                        end else begin
                            wbin_q  <= wbin_d;
                            wgray_q <= bin2gray(wbin_d);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end

                S_IDLE: begin
`ifdef SB_RX_IDLE_CHECK_EN
                    if (dataPin_i) begin
                        ferr_tgl_q <= ~ferr_tgl_q;
                        idle_cnt_q <= '0;
                        state_q    <= S_RESYNC;
                    end else
`endif
                    if (idle_cnt_q == ICW'(IDLE_UI - 1)) begin
                        idle_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= S_RECV;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end

`ifdef SB_RX_IDLE_CHECK_EN
                // Wait for a full run of IDLE_UI consecutive zero UIs.
                S_RESYNC: begin
                    if (dataPin_i) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == ICW'(IDLE_UI - 1)) begin
                        idle_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= S_RECV;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= S_RECV;
                end
            endcase
        end
    end

    // Read pointer (gray) brought into the serial domain.
    always_ff @(negedge clkPin_i or posedge reset) begin
        if (reset) begin
            rsync_q <= '0;
        end else begin
            rsync_q <= {rsync_q[SYNC_STG-2:0], rgray_q};
        end
    end

    // FIFO storage. It is written from the serial domain and read from the
    // system clock domain through a registered read port.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    always_ff @(negedge clkPin_i) begin
        if (wr_en) begin
            mem[wbin_q[AW-1:0]] <= wr_word;
        end
    end

    // =========================================================================
    // System clock domain
    // =========================================================================
    logic [SYNC_STG-1:0][PW-1:0]  wsync_q;
    logic [PW-1:0]                wsync_bin;
    logic [PW-1:0]                rbin_q;
    logic [PW-1:0]                rgray_q;
    logic [PW-1:0]                rbin_d;
    logic                         pop;
    logic [DATA_W-1:0]            data_q;
    logic                         valid_q;
    logic [PW-1:0]                level_q;
    logic [SYNC_STG-1:0]          ovf_sync_q;
    logic                         ovf_prev_q;
    logic                         overflow_q;

    // Convert the synchronised gray write pointer to binary.
    for (genvar gi = 0; gi < PW; gi++) begin : g_g2b
        assign wsync_bin[gi] = ^wsync_q[SYNC_STG-1][PW-1:gi];
    end

    assign pop    = valid_q && ready_i;
    assign rbin_d = rbin_q + PW'(pop);

    // All read-side outputs are computed from the next read pointer. The
    // head word and the valid flag therefore move together in one cycle,
    // which lets back-to-back pops run at one word per clock. The slot at
    // rbin_d is read even when the FIFO is empty. A write to that slot can
    // land during the read, but valid_q is low then. The slot is read again
    // once the synchronised write pointer shows the write as complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wsync_q    <= '0;
            rbin_q     <= '0;
            rgray_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            level_q    <= '0;
            ovf_sync_q <= '0;
            ovf_prev_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wsync_q    <= {wsync_q[SYNC_STG-2:0], wgray_q};
            rbin_q     <= rbin_d;
            rgray_q    <= bin2gray(rbin_d);
            data_q     <= mem[rbin_d[AW-1:0]];
            valid_q    <= (rbin_d != wsync_bin);
            level_q    <= wsync_bin - rbin_d;
            ovf_sync_q <= {ovf_sync_q[SYNC_STG-2:0], ovf_tgl_q};
            ovf_prev_q <= ovf_sync_q[SYNC_STG-1];
            overflow_q <= ovf_sync_q[SYNC_STG-1] ^ ovf_prev_q;
        end
    end

`ifdef SB_RX_IDLE_CHECK_EN
    logic [SYNC_STG-1:0] ferr_sync_q;
    logic                ferr_prev_q;
    logic                ferr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ferr_sync_q <= '0;
            ferr_prev_q <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ferr_sync_q <= {ferr_sync_q[SYNC_STG-2:0], ferr_tgl_q};
            ferr_prev_q <= ferr_sync_q[SYNC_STG-1];
            ferr_q      <= ferr_sync_q[SYNC_STG-1] ^ ferr_prev_q;
        end
    end

    assign framing_err_o = ferr_q;
`else
    assign framing_err_o = 1'b0;
`endif

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;

endmodule
